// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default widths for the UART RX controller
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int DIV_W_DEF     = 16;
  localparam int ERR_CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } state_e;

  typedef struct packed {
    logic                     err;
    logic [DATA_BITS_DEF-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - received-byte FIFO with flush; a pop frees room for a same-cycle push
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(rx_entry_t)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX sequencer: baud tick, receiver reset, byte capture FIFO, status
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          clr_status,
  output logic                          tick,
  output logic                          rx_rst_n,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_done,
  input  logic                          rx_error,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_err,
  output logic                          overrun,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  state_e           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;
  logic             rx_done_q;
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic             ov_set;
  logic             err_inc;
  logic [DATA_BITS:0] head;

  assign div_eff   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign flush     = (state == RUN) && !cfg_en;
  // Only the rising edge of rx_done captures, so a long done pulse yields one entry.
  assign push      = (state == RUN) && cfg_en && rx_done && !rx_done_q;
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign {out_err, out_data} = head;
  assign ov_set    = push && full && !pop;
  assign err_inc   = push && rx_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DISABLED;
      rx_rst_n  <= 1'b0;
      cnt       <= '0;
      div_q     <= '0;
      tick      <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      case (state)
        DISABLED: begin
          tick      <= 1'b0;
          cnt       <= '0;
          rx_done_q <= rx_done;
          if (cfg_en) begin
            state    <= RUN;
            rx_rst_n <= 1'b1;
            div_q    <= div_eff;
          end
        end
        RUN: begin
          if (!cfg_en) begin
            state     <= DISABLED;
            rx_rst_n  <= 1'b0;
            cnt       <= '0;
            tick      <= 1'b0;
            rx_done_q <= 1'b0;
          end else begin
            rx_done_q <= rx_done;
            // New divisor is only picked up at the wrap so the current period completes.
            if (cnt == div_q - 1'b1) begin
              cnt   <= '0;
              div_q <= div_eff;
              tick  <= 1'b1;
            end else begin
              cnt  <= cnt + 1'b1;
              tick <= 1'b0;
            end
          end
        end
        default: state <= DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      if (ov_set)          overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;

      if (err_inc) begin
        if (clr_status)             err_count <= ERR_CNT_W'(1);
        else if (err_count != '1)   err_count <= err_count + 1'b1;
      end else if (clr_status) begin
        err_count <= '0;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({rx_error, rx_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver datapath: generates the baud tick from a programmable divisor, holds the receiver in reset while disabled, and captures each received byte and its error flag into a small FIFO. It presents the FIFO to the register/APB side through a valid/ready stream and keeps sticky overrun and saturating error-count status. It sits between the APB register block and the UART RX core.

Parameters:
DATA_BITS, 8, width of the received data word; matches the receiver.
FIFO_DEPTH, 4, number of FIFO entries; power of two, at least 2.
DIV_W, 16, width of the baud divisor.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock for all logic.
rst_n  input  1  asynchronous active-low reset.
cfg_en  input  1  receiver enable, level.
cfg_div  input  DIV_W  clocks per tick; 0 is treated as 1.
clr_status  input  1  one-cycle pulse; clears overrun and err_count.
tick  output  1  baud tick to the receiver, one clk wide.
rx_rst_n  output  1  active-low reset to the receiver.
rx_data  input  DATA_BITS  byte from the receiver.
rx_done  input  1  receiver byte-ready; may stay high for more than one clk.
rx_error  input  1  receiver error flag; qualified by rx_done.
out_valid  output  1  FIFO not empty.
out_ready  input  1  consumer accepts the head entry.
out_data  output  DATA_BITS  head entry data.
out_err  output  1  head entry error flag.
overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
err_count  output  ERR_CNT_W  saturating count of bytes received with rx_error set.
fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): state DISABLED, tick 0, rx_rst_n 0, FIFO empty, out_valid 0, out_data 0, out_err 0, overrun 0, err_count 0, fifo_level 0, divisor counter 0, rx_done_q 0.
- FSM states:
  - DISABLED: rx_rst_n 0, counter held at 0, no tick.
  - DISABLED to RUN when cfg_en is 1. rx_rst_n goes to 1 on that same clock edge (registered).
  - RUN to DISABLED when cfg_en is 0. rx_rst_n goes to 0, the FIFO is flushed (level 0, out_valid 0 next cycle), and counter and rx_done_q clear. overrun and err_count are kept.
- Tick generation in RUN:
  - div_eff = max(cfg_div, 1), latched into div_q on entry to RUN and at each counter wrap.
  - Counter runs 0..div_q-1. tick is registered and is 1 in the cycle after the counter equals div_q-1.
  - Period is exactly div_q clocks. With div_q = 1, tick is high every cycle.
  - A cfg_div change mid-period takes effect at the next wrap only.
- Capture:
  - rx_done_q is a registered copy of rx_done.
  - Push only when state is RUN, rx_done is 1 and rx_done_q is 0 (rising edge). A multi-cycle rx_done gives exactly one push.
  - The push writes {rx_error, rx_data} as sampled in that cycle.
  - out_valid rises the cycle after a push into an empty FIFO (1-cycle latency).
- Pop: the head entry is removed when out_valid and out_ready are both 1. out_data and out_err are always the head entry; they are don't-care when out_valid is 0 but held stable.
- Full FIFO:
  - A push without a simultaneous pop drops the byte, sets overrun, and leaves FIFO contents unchanged.
  - A push and pop in the same cycle while full: both succeed and the level stays FIFO_DEPTH. No overrun.
- Empty FIFO: out_ready is ignored; no underflow.
- Pointers wrap modulo FIFO_DEPTH. Level arithmetic uses an extra bit so full and empty are distinct.
- err_count:
  - Increments on each accepted or dropped rising-edge push with rx_error 1.
  - Saturates at 2^ERR_CNT_W-1.
- clr_status:
  - Clears overrun and err_count.
  - If a set/increment event occurs in the same cycle, the result is overrun 1 and err_count 1 (the event wins over the clear).
- Reset mid-frame: the FIFO and all status clear asynchronously, and the receiver is held in reset through rx_rst_n.

Decomposition:
- Package uart_pkg holds:
  - the state enum (DISABLED, RUN);
  - the entry struct rx_entry_t {err, data[DATA_BITS]};
  - default constants for the DIV_W and ERR_CNT_W widths.
- Sub-module uart_rx_fifo: synchronous FIFO with push/pop/full/empty/level and a flush input, parameterised by depth and rx_entry_t width.

Test Plan:
- Enable with cfg_div=4 -> rx_rst_n 1 on the enable edge; tick pulses every 4 clks; cfg_div=0 gives tick on every cycle; disable -> tick stops and rx_rst_n 0.
- rx_done held high 3 clks with rx_data=0xA5, rx_error=0 -> exactly one entry; out_valid rises 1 clk after the edge; out_data=0xA5, out_err=0.
- 5 bytes (0x01..0x05) with out_ready=0, depth 4 -> level 4, 0x05 dropped, overrun=1; then drain -> 0x01..0x04 in order.
- FIFO full, push 0x06 in the same cycle as out_ready=1 -> level stays 4, overrun unchanged, tail entry is 0x06.
- 300 bytes with rx_error=1 -> err_count saturates at 255; clr_status coincident with an error byte -> err_count=1.
- Disable with 2 entries queued, then async rst_n pulse mid-period -> FIFO flushed, out_valid 0, all outputs at reset values.
